// File: rtl/conv_adder_tree.sv
// Channel-summing stage: adds NUM_CH signed products plus a per-map bias, saturates
// to DW bits with optional ReLU. Three registered stages plus a window-end marker.
module conv_adder_tree #(
  parameter int NUM_CH     = 18,
  parameter int DW         = 16,
  parameter int GROUP      = 3,
  parameter int NUM_BIAS   = 36,
  parameter int NUM_KERNEL = 25,
  localparam int BW = (NUM_BIAS > 1) ? $clog2(NUM_BIAS) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [NUM_CH*DW-1:0] a_in,
  input  logic                 in_valid,
  input  logic [BW-1:0]        b_ind,
  input  logic                 relu_en,
  input  logic                 bias_we,
  input  logic [BW-1:0]        bias_addr,
  input  logic signed [DW-1:0] bias_data,
  input  logic                 last_ready,
  output logic signed [DW-1:0] add_out,
  output logic                 out_valid,
  output logic                 out_last,
  output logic                 ready
);

  localparam int NG    = (NUM_CH + GROUP - 1) / GROUP;
  localparam int GW    = DW + $clog2(GROUP) + 1;
  localparam int ACC_W = DW + $clog2(NUM_CH + 1) + 1;
  localparam int CW    = (NUM_KERNEL > 1) ? $clog2(NUM_KERNEL) : 1;
  localparam int PADW  = NG * GROUP * DW;

  localparam logic [BW:0]              NB      = (BW + 1)'(NUM_BIAS);
  localparam logic signed [ACC_W-1:0]  SAT_MAX = {{(ACC_W - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  SAT_MIN = ~SAT_MAX;
  localparam logic [CW-1:0]            CNT_END = CW'(NUM_KERNEL - 1);

  logic [PADW-1:0]          w_a_pad;
  logic [NG*GW-1:0]         w_g_flat;
  logic [NG*GW-1:0]         r_g_flat;
  logic signed [DW-1:0]     r_bias_mem [NUM_BIAS];
  logic signed [DW-1:0]     w_bias_rd;
  logic signed [DW-1:0]     r_bias;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DW-1:0]     w_sat;
  logic                     r_v1;
  logic                     r_v2;
  logic [CW-1:0]            r_cnt;
  logic [2:0]               r_rdy;

  // Channels beyond NUM_CH in the last group read as zero.
  always_comb begin
    w_a_pad = '0;
    w_a_pad[NUM_CH*DW-1:0] = a_in;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      logic signed [GW-1:0] w_sum;
      always_comb begin
        w_sum = '0;
        for (int j = 0; j < GROUP; j++) begin
          w_sum = w_sum + GW'($signed(w_a_pad[(gi*GROUP + j)*DW +: DW]));
        end
      end
      assign w_g_flat[gi*GW +: GW] = w_sum;
    end
  endgenerate

  assign w_bias_rd = ({1'b0, b_ind} < NB) ? r_bias_mem[b_ind] : '0;

  always_comb begin
    w_acc = ACC_W'(r_bias);
    for (int i = 0; i < NG; i++) begin
      w_acc = w_acc + ACC_W'($signed(r_g_flat[i*GW +: GW]));
    end
  end

  always_comb begin
    if (r_acc > SAT_MAX) begin
      w_sat = SAT_MAX[DW-1:0];
    end else if (r_acc < SAT_MIN) begin
      w_sat = SAT_MIN[DW-1:0];
    end else begin
      w_sat = r_acc[DW-1:0];
    end
    if (relu_en && w_sat[DW-1]) begin
      w_sat = '0;
    end
  end

  // A write only lands at the edge, so a same-cycle read in stage 1 sees the old value.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BIAS; k++) begin
        r_bias_mem[k] <= '0;
      end
    end else if (bias_we && ({1'b0, bias_addr} < NB)) begin
      r_bias_mem[bias_addr] <= bias_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (in_valid) begin
      r_g_flat <= w_g_flat;
      r_bias   <= w_bias_rd;
    end
    if (r_v1) begin
      r_acc <= w_acc;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      add_out   <= '0;
      r_cnt     <= '0;
    end else begin
      r_v1      <= in_valid;
      r_v2      <= r_v1;
      out_valid <= r_v2;
      out_last  <= r_v2 && (r_cnt == CNT_END);
      if (r_v2) begin
        add_out <= w_sat;
        r_cnt   <= (r_cnt == CNT_END) ? '0 : r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_rdy <= '1;
    end else begin
      r_rdy <= {r_rdy[1:0], last_ready};
    end
  end

  assign ready = r_rdy[2];

endmodule
